// File: rtl/uart_rx_framed.sv
// uart_rx_framed: oversampled UART receiver with majority voting, error/break flags and a valid/ready output register.
module uart_rx_framed #(
  parameter int D_BIT      = 8,
  parameter int OVS        = 16,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_tick,
  input  logic             rx,
  output logic [D_BIT-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overrun,
  output logic             break_det
);
  localparam int SW = $clog2(OVS);
  localparam int NW = $clog2(D_BIT);
  localparam logic [SW-1:0] S_HALF = SW'(OVS / 2 - 1);
  localparam logic [SW-1:0] S_M3 = SW'(OVS - 3);
  localparam logic [SW-1:0] S_M2 = SW'(OVS - 2);
  localparam logic [SW-1:0] S_M1 = SW'(OVS - 1);
  localparam logic [NW-1:0] N_LAST = NW'(D_BIT - 1);
  localparam logic [NW-1:0] N_STOP = NW'(STOP_BITS - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK_WAIT} state_t;
  state_t state, state_n;
  logic rx_m, rxs;
  logic [SW-1:0] s, s_n;
  logic [NW-1:0] n, n_n;
  logic [D_BIT-1:0] data, data_n;
  logic v0, v0_n, v1, v1_n, perr, perr_n, ferr, ferr_n, zero, zero_n, done, bv, last;
  assign bv = (v0 & v1) | (v0 & rxs) | (v1 & rxs);
  assign last = s == S_M1;
  always_comb begin
    state_n = state;
    s_n = s;
    n_n = n;
    data_n = data;
    v0_n = v0;
    v1_n = v1;
    perr_n = perr;
    ferr_n = ferr;
    zero_n = zero;
    done = 1'b0;
    if (s_tick) begin
      s_n = s + 1'b1;
      if (s == S_M3) v0_n = rxs;
      if (s == S_M2) v1_n = rxs;
      case (state)
        IDLE: begin
          s_n = '0;
          if (!rxs) state_n = START;
        end
        START: if (s == S_HALF) begin
          s_n = '0;
          n_n = '0;
          zero_n = 1'b1;
          perr_n = 1'b0;
          ferr_n = 1'b0;
          state_n = rxs ? IDLE : DATA;
        end
        DATA: if (last) begin
          s_n = '0;
          data_n = {bv, data[D_BIT-1:1]};
          zero_n = zero & ~bv;
          n_n = n + 1'b1;
          if (n == N_LAST) begin
            n_n = '0;
            state_n = (PARITY_EN != 0) ? PARITY : STOP;
          end
        end
        PARITY: if (last) begin
          s_n = '0;
          perr_n = ^{data, bv} ^ (PARITY_ODD != 0);
          zero_n = zero & ~bv;
          state_n = STOP;
        end
        STOP: if (last) begin
          s_n = '0;
          ferr_n = ferr | ~bv;
          zero_n = zero & ~bv;
          n_n = n + 1'b1;
          if (n == N_STOP) begin
            n_n = '0;
            done = 1'b1;
            state_n = zero_n ? BRK_WAIT : IDLE;
          end
        end
        BRK_WAIT: begin
          s_n = '0;
          if (rxs) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rx_m <= 1'b1;
      rxs <= 1'b1;
      state <= IDLE;
      s <= '0;
      n <= '0;
      data <= '0;
      v0 <= 1'b0;
      v1 <= 1'b0;
      perr <= 1'b0;
      ferr <= 1'b0;
      zero <= 1'b0;
    end else begin
      rx_m <= rx;
      rxs <= rx_m;
      state <= state_n;
      s <= s_n;
      n <= n_n;
      data <= data_n;
      v0 <= v0_n;
      v1 <= v1_n;
      perr <= perr_n;
      ferr <= ferr_n;
      zero <= zero_n;
    end
  // a completed frame that finds the register occupied and not being drained is dropped
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      dout <= '0;
      dout_valid <= 1'b0;
      parity_err <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
      break_det <= 1'b0;
    end else begin
      overrun <= done && dout_valid && !dout_ready;
      break_det <= done && zero_n;
      if (done && (!dout_valid || dout_ready)) begin
        dout <= data_n;
        parity_err <= perr_n;
        frame_err <= ferr_n;
        dout_valid <= 1'b1;
      end else if (!done && dout_valid && dout_ready) begin
        dout_valid <= 1'b0;
        parity_err <= 1'b0;
        frame_err <= 1'b0;
      end
    end
endmodule

// File: tb/tb_uart_rx_framed.sv
// tb_uart_rx_framed: directed checks of 8N1, 8E1 and 8N2 receivers sharing clock, tick and ready.
module tb_uart_rx_framed;
  logic clk = 1'b0, rst = 1'b1, s_tick, dout_ready = 1'b1;
  logic [1:0] tc = '0;
  logic rx_l [3];
  logic [7:0] dd [3];
  logic dv [3], pe [3], fe [3], ov [3], bk [3];
  int vcnt [3], ocnt [3], bcnt [3];
  logic [7:0] last_d [3];
  logic last_pe [3], last_fe [3];
  int ncmp = 0, nfail = 0;
  int v0, o0, b0;
  always #5 clk = ~clk;
  always @(posedge clk) tc <= rst ? 2'd0 : tc + 2'd1;
  assign s_tick = tc == 2'd3;
  uart_rx_framed u_n1 (.clk(clk), .rst(rst), .s_tick(s_tick), .rx(rx_l[0]), .dout(dd[0]), .dout_valid(dv[0]),
    .dout_ready(dout_ready), .parity_err(pe[0]), .frame_err(fe[0]), .overrun(ov[0]), .break_det(bk[0]));
  uart_rx_framed #(.PARITY_EN(1)) u_e1 (.clk(clk), .rst(rst), .s_tick(s_tick), .rx(rx_l[1]), .dout(dd[1]),
    .dout_valid(dv[1]), .dout_ready(dout_ready), .parity_err(pe[1]), .frame_err(fe[1]), .overrun(ov[1]),
    .break_det(bk[1]));
  uart_rx_framed #(.STOP_BITS(2)) u_n2 (.clk(clk), .rst(rst), .s_tick(s_tick), .rx(rx_l[2]), .dout(dd[2]),
    .dout_valid(dv[2]), .dout_ready(dout_ready), .parity_err(pe[2]), .frame_err(fe[2]), .overrun(ov[2]),
    .break_det(bk[2]));
  initial for (int i = 0; i < 3; i++) begin
    vcnt[i] = 0;
    ocnt[i] = 0;
    bcnt[i] = 0;
    last_d[i] = '0;
    last_pe[i] = 1'b0;
    last_fe[i] = 1'b0;
    rx_l[i] = 1'b1;
  end
  always @(negedge clk)
    for (int k = 0; k < 3; k++) begin
      if (dv[k] === 1'b1) begin
        vcnt[k]++;
        last_d[k] = dd[k];
        last_pe[k] = pe[k];
        last_fe[k] = fe[k];
      end
      if (ov[k] === 1'b1) ocnt[k]++;
      if (bk[k] === 1'b1) bcnt[k]++;
    end
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic tick_wait();
    do @(negedge clk); while (!s_tick);
    @(posedge clk);
    #1;
  endtask
  task automatic bit_time(input int nb);
    repeat (nb * 16) tick_wait();
  endtask
  task automatic send(input int w, input logic [15:0] bits, input int nb);
    for (int i = 0; i < nb; i++) begin
      rx_l[w] = bits[i];
      bit_time(1);
    end
    rx_l[w] = 1'b1;
    bit_time(2);
  endtask
  task automatic snap();
    v0 = vcnt[0];
    o0 = ocnt[0];
    b0 = bcnt[0];
  endtask
  initial begin
    repeat (3) @(negedge clk);
    check("rst_valid", 16'(dv[0]), 16'h0);
    check("rst_dout", 16'(dd[0]), 16'h0);
    check("rst_errs", 16'({pe[0], fe[0]}), 16'h0);
    check("rst_pulses", 16'({ov[0], bk[0]}), 16'h0);
    rst = 1'b0;
    bit_time(1);
    snap();
    send(0, {6'b0, 1'b1, 8'hA5, 1'b0}, 10);
    check("a5_vcnt", 16'(vcnt[0] - v0), 16'd1);
    check("a5_dout", 16'(last_d[0]), 16'hA5);
    check("a5_errs", 16'({last_pe[0], last_fe[0]}), 16'h0);
    check("a5_valid_gone", 16'(dv[0]), 16'h0);
    send(1, {5'b0, 1'b1, 1'b0, 8'h07, 1'b0}, 11);
    check("e1_p0_dout", 16'(last_d[1]), 16'h07);
    check("e1_p0_perr", 16'(last_pe[1]), 16'h1);
    send(1, {5'b0, 1'b1, 1'b1, 8'h07, 1'b0}, 11);
    check("e1_p1_dout", 16'(last_d[1]), 16'h07);
    check("e1_p1_perr", 16'(last_pe[1]), 16'h0);
    check("e1_vcnt", 16'(vcnt[1]), 16'd2);
    send(2, {5'b0, 1'b0, 1'b1, 8'h3C, 1'b0}, 11);
    check("n2_dout", 16'(last_d[2]), 16'h3C);
    check("n2_ferr", 16'(last_fe[2]), 16'h1);
    snap();
    rx_l[0] = 1'b0;
    repeat (5) tick_wait();
    rx_l[0] = 1'b1;
    bit_time(3);
    check("glitch_vcnt", 16'(vcnt[0] - v0), 16'd0);
    check("glitch_valid", 16'(dv[0]), 16'h0);
    dout_ready = 1'b0;
    snap();
    send(0, {6'b0, 1'b1, 8'h11, 1'b0}, 10);
    send(0, {6'b0, 1'b1, 8'h22, 1'b0}, 10);
    @(negedge clk);
    check("ovr_dout", 16'(dd[0]), 16'h11);
    check("ovr_valid", 16'(dv[0]), 16'h1);
    check("ovr_count", 16'(ocnt[0] - o0), 16'd1);
    dout_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("drain_valid", 16'(dv[0]), 16'h0);
    snap();
    rx_l[0] = 1'b0;
    bit_time(20);
    rx_l[0] = 1'b1;
    bit_time(2);
    check("brk_count", 16'(bcnt[0] - b0), 16'd1);
    check("brk_dout", 16'(last_d[0]), 16'h00);
    check("brk_ferr", 16'(last_fe[0]), 16'h1);
    check("brk_vcnt", 16'(vcnt[0] - v0), 16'd1);
    send(0, {6'b0, 1'b1, 8'h55, 1'b0}, 10);
    check("post_brk_dout", 16'(last_d[0]), 16'h55);
    check("post_brk_ferr", 16'(last_fe[0]), 16'h0);
    check("post_brk_count", 16'(bcnt[0] - b0), 16'd1);
    check("ovr_total", 16'(ocnt[0]), 16'd1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
